// File: rtl/obj_sprite_reader.sv
// Sprite-ROM reader for one object: scan-position hit test, ROM addressing, pixel-on flag, life cycle.
// Latency: pix_x/pix_y at cycle N -> rom_x/rom_y/rom_en at N+1 -> pix_on at N+2 (fixed).
// Backpressure: pos_valid/pos_ready into a one-entry holding register, drained only at frame_start.
// Optional feature macro: OBJ_SPRITE_MIRROR_EN (adds i_mirror, horizontal flip of rom_x).
module obj_sprite_reader #(
  parameter int OBJ_W        = 6,
  parameter int OBJ_H        = 6,
  parameter int HW           = 10,
  parameter int FLASH_FRAMES = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [HW-1:0] i_pix_x,
  input  logic [HW-1:0] i_pix_y,
  input  logic          i_frame_start,
  input  logic [HW-1:0] i_pos_x,
  input  logic [HW-1:0] i_pos_y,
  input  logic          i_pos_valid,
  output logic          o_pos_ready,
  input  logic          i_hit,
  output logic [2:0]    o_rom_x,
  output logic [2:0]    o_rom_y,
  output logic          o_rom_en,
  input  logic          i_rom_data,
  output logic          o_pix_on,
`ifdef OBJ_SPRITE_MIRROR_EN
  input  logic          i_mirror,
`endif
  output logic          o_obj_alive
);

  localparam int CW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  typedef enum logic [1:0] {
    ST_DEAD  = 2'd0,
    ST_ALIVE = 2'd1,
    ST_FLASH = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_flash_cnt;
  logic [CW-1:0] w_flash_cnt_nxt;
  logic          r_alive;

  logic          r_pend_vld;
  logic [HW-1:0] r_pend_x;
  logic [HW-1:0] r_pend_y;
  logic [HW-1:0] r_cur_x;
  logic [HW-1:0] r_cur_y;

  logic          w_xfer;
  logic          w_apply;
  logic [HW-1:0] w_new_x;
  logic [HW-1:0] w_new_y;

  logic [HW-1:0] w_lx;
  logic [HW-1:0] w_ly;
  logic          w_inside;
  logic          w_show;
  logic [2:0]    w_rom_x;

  logic [2:0]    r_rom_x;
  logic [2:0]    r_rom_y;
  logic          r_rom_en;
  logic          r_pix_on;

  // A transfer coinciding with frame_start bypasses the holding register.
  assign o_pos_ready = ~r_pend_vld;
  assign w_xfer      = i_pos_valid & ~r_pend_vld;
  assign w_apply     = i_frame_start & (r_pend_vld | w_xfer);
  assign w_new_x     = r_pend_vld ? r_pend_x : i_pos_x;
  assign w_new_y     = r_pend_vld ? r_pend_y : i_pos_y;

  // Holding register and frame-synchronous position update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_vld <= 1'b0;
      r_pend_x   <= '0;
      r_pend_y   <= '0;
      r_cur_x    <= '0;
      r_cur_y    <= '0;
    end else if (i_frame_start) begin
      r_pend_vld <= 1'b0;
      if (w_apply) begin
        r_cur_x <= w_new_x;
        r_cur_y <= w_new_y;
      end
    end else if (w_xfer) begin
      r_pend_vld <= 1'b1;
      r_pend_x   <= i_pos_x;
      r_pend_y   <= i_pos_y;
    end
  end

  // Life-cycle state register; obj_alive follows the next state on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_DEAD;
      r_flash_cnt <= '0;
      r_alive     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_flash_cnt <= w_flash_cnt_nxt;
      r_alive     <= (w_state_nxt != ST_DEAD);
    end
  end

  // Next-state logic: respawn on applied position, hit starts the flash, flash ends after FLASH_FRAMES frames.
  always_comb begin
    w_state_nxt     = r_state;
    w_flash_cnt_nxt = r_flash_cnt;
    case (r_state)
      ST_DEAD: begin
        if (w_apply) w_state_nxt = ST_ALIVE;
      end
      ST_ALIVE: begin
        if (i_hit) begin
          w_state_nxt     = ST_FLASH;
          w_flash_cnt_nxt = '0;
        end
      end
      ST_FLASH: begin
        if (i_frame_start) begin
          if (r_flash_cnt == CW'(FLASH_FRAMES - 1)) begin
            w_state_nxt     = ST_DEAD;
            w_flash_cnt_nxt = '0;
          end else begin
            w_flash_cnt_nxt = r_flash_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt     = ST_DEAD;
        w_flash_cnt_nxt = '0;
      end
    endcase
  end

  // Output decode: visibility from state, wrapped offsets against the current position.
  always_comb begin
    w_show   = (r_state == ST_ALIVE) | ((r_state == ST_FLASH) & r_flash_cnt[0]);
    w_lx     = i_pix_x - r_cur_x;
    w_ly     = i_pix_y - r_cur_y;
    w_inside = (w_lx < HW'(OBJ_W)) && (w_ly < HW'(OBJ_H));
`ifdef OBJ_SPRITE_MIRROR_EN
    w_rom_x  = i_mirror ? (3'(OBJ_W - 1) - w_lx[2:0]) : w_lx[2:0];
`else
    w_rom_x  = w_lx[2:0];
`endif
  end

  // Two-stage pipeline: ROM address stage, then registered pixel-on from the ROM bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_x  <= '0;
      r_rom_y  <= '0;
      r_rom_en <= 1'b0;
      r_pix_on <= 1'b0;
    end else begin
      r_rom_x  <= w_rom_x;
      r_rom_y  <= w_ly[2:0];
      r_rom_en <= w_inside & w_show;
      r_pix_on <= r_rom_en & i_rom_data;
    end
  end

  assign o_rom_x     = r_rom_x;
  assign o_rom_y     = r_rom_y;
  assign o_rom_en    = r_rom_en;
  assign o_pix_on    = r_pix_on;
  assign o_obj_alive = r_alive;

endmodule

// File: tb/tb_obj_sprite_reader.sv
// Bench for obj_sprite_reader: directed scenarios plus a randomized run against a frame-level model.
// The model tracks position, pending offer queue and life cycle in plain integers.
// Build with +define+OBJ_SPRITE_MIRROR_EN to also exercise the mirror port.
module tb_obj_sprite_reader;

  localparam int M_DEAD  = 0;
  localparam int M_ALIVE = 1;
  localparam int M_FLASH = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pix_x, pix_y, pos_x, pos_y;
  logic       frame_start, pos_valid, hit, mirror;
  logic       pos_ready, rom_en, rom_data, pix_on, obj_alive;
  logic [2:0] rom_x, rom_y;
  logic [63:0] bitmap;

  int checks = 0;
  int errors = 0;

  // model state
  int m_state, m_cnt, m_cx, m_cy;
  int pq_x[$];
  int pq_y[$];
  bit e_en, e_pix, e_alive, e_ready;
  int e_rx, e_ry;

  always #5 clk = ~clk;

  assign rom_data = rom_en ? bitmap[{rom_y, rom_x}] : 1'b0;

  obj_sprite_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_pix_x      (pix_x),
    .i_pix_y      (pix_y),
    .i_frame_start(frame_start),
    .i_pos_x      (pos_x),
    .i_pos_y      (pos_y),
    .i_pos_valid  (pos_valid),
    .o_pos_ready  (pos_ready),
    .i_hit        (hit),
    .o_rom_x      (rom_x),
    .o_rom_y      (rom_y),
    .o_rom_en     (rom_en),
    .i_rom_data   (rom_data),
    .o_pix_on     (pix_on),
`ifdef OBJ_SPRITE_MIRROR_EN
    .i_mirror     (mirror),
`endif
    .o_obj_alive  (obj_alive)
  );

  task automatic model_reset();
    m_state = M_DEAD; m_cnt = 0; m_cx = 0; m_cy = 0;
    pq_x.delete(); pq_y.delete();
    e_en = 0; e_pix = 0; e_alive = 0; e_ready = 1; e_rx = 0; e_ry = 0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, return #1 after the edge.
  task automatic step(input int px, input int py, input bit fs, input bit pv,
                      input int qx, input int qy, input bit h, input bit mir);
    int lx, ly, nx, ny;
    bit show, rdy, xfer, applied;
    @(negedge clk);
    pix_x = 10'(px); pix_y = 10'(py); frame_start = fs; pos_valid = pv;
    pos_x = 10'(qx); pos_y = 10'(qy); hit = h; mirror = mir;
    @(posedge clk);
    e_pix = e_en && bitmap[e_ry * 8 + e_rx];
    lx = (px - m_cx) & 1023;
    ly = (py - m_cy) & 1023;
    show = (m_state == M_ALIVE) || (m_state == M_FLASH && (m_cnt % 2) == 1);
    e_en = (lx < 6) && (ly < 6) && show;
    e_rx = mir ? ((5 - (lx % 8)) & 7) : (lx % 8);
    e_ry = ly % 8;
    rdy = (pq_x.size() == 0);
    xfer = pv && rdy;
    applied = 0; nx = 0; ny = 0;
    if (fs) begin
      if (!rdy) begin nx = pq_x.pop_front(); ny = pq_y.pop_front(); applied = 1; end
      else if (xfer) begin nx = qx; ny = qy; applied = 1; end
    end else if (xfer) begin
      pq_x.push_back(qx); pq_y.push_back(qy);
    end
    case (m_state)
      M_DEAD:  if (applied) m_state = M_ALIVE;
      M_ALIVE: if (h) begin m_state = M_FLASH; m_cnt = 0; end
      default: if (fs) begin
                 if (m_cnt == 7) begin m_state = M_DEAD; m_cnt = 0; end
                 else m_cnt = m_cnt + 1;
               end
    endcase
    if (applied) begin m_cx = nx; m_cy = ny; end
    e_alive = (m_state != M_DEAD);
    e_ready = (pq_x.size() == 0);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; pix_x = 0; pix_y = 0; frame_start = 0; pos_valid = 0;
    pos_x = 0; pos_y = 0; hit = 0; mirror = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL reset_rom_en got %b want 0", rom_en); end
    checks++; if (pix_on !== 1'b0) begin errors++; $display("FAIL reset_pix_on got %b want 0", pix_on); end
    checks++; if (pos_ready !== 1'b1) begin errors++; $display("FAIL reset_pos_ready got %b want 1", pos_ready); end
    checks++; if (obj_alive !== 1'b0) begin errors++; $display("FAIL reset_obj_alive got %b want 0", obj_alive); end
    checks++; if ({rom_x, rom_y} !== 6'd0) begin errors++; $display("FAIL reset_rom_xy got %0d,%0d want 0,0", rom_x, rom_y); end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_spawn();
    step(0, 0, 0, 1, 100, 50, 0, 0);
    checks++; if (pos_ready !== 1'b0) begin errors++; $display("FAIL spawn_ready_drop got %b want 0", pos_ready); end
    step(0, 0, 1, 0, 0, 0, 0, 0);
    checks++; if (obj_alive !== 1'b1) begin errors++; $display("FAIL spawn_alive got %b want 1", obj_alive); end
    checks++; if (pos_ready !== 1'b1) begin errors++; $display("FAIL spawn_ready_back got %b want 1", pos_ready); end
  endtask

  task automatic test_scan();
    step(102, 53, 0, 0, 0, 0, 0, 0);
    checks++; if ({rom_en, rom_x, rom_y} !== {1'b1, 3'd2, 3'd3}) begin errors++;
      $display("FAIL scan_inside got en=%b x=%0d y=%0d want en=1 x=2 y=3", rom_en, rom_x, rom_y); end
    step(99, 50, 0, 0, 0, 0, 0, 0);
    checks++; if (pix_on !== 1'b1) begin errors++; $display("FAIL scan_pix_on got %b want 1", pix_on); end
    checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL scan_left_edge got rom_en=%b want 0", rom_en); end
    step(106, 50, 0, 0, 0, 0, 0, 0);
    checks++; if ({rom_en, pix_on} !== 2'b00) begin errors++; $display("FAIL scan_right_edge got en=%b pix=%b want 0,0", rom_en, pix_on); end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (pix_on !== 1'b0) begin errors++; $display("FAIL scan_outside_pix got %b want 0", pix_on); end
  endtask

  task automatic test_position();
    step(0, 0, 0, 1, 10, 10, 0, 0);
    step(0, 0, 0, 1, 20, 20, 0, 0);
    checks++; if (pos_ready !== 1'b0) begin errors++; $display("FAIL pos_stall got ready=%b want 0", pos_ready); end
    step(11, 11, 0, 1, 20, 20, 0, 0);
    checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL pos_not_early got rom_en=%b want 0", rom_en); end
    step(102, 53, 1, 1, 20, 20, 0, 0);
    checks++; if (rom_en !== 1'b1) begin errors++; $display("FAIL pos_old_until_frame got rom_en=%b want 1", rom_en); end
    checks++; if (pos_ready !== 1'b1) begin errors++; $display("FAIL pos_ready_after_frame got %b want 1", pos_ready); end
    step(12, 13, 0, 1, 20, 20, 0, 0);  // (20,20) now lands in the holding register
    checks++; if ({rom_en, rom_x, rom_y} !== {1'b1, 3'd2, 3'd3}) begin errors++;
      $display("FAIL pos_moved got en=%b x=%0d y=%0d want 1,2,3", rom_en, rom_x, rom_y); end
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(200, 100, 1, 1, 200, 100, 0, 0);
    checks++; if (pos_ready !== 1'b1) begin errors++; $display("FAIL pos_bypass_ready got %b want 1", pos_ready); end
    step(200, 100, 0, 0, 0, 0, 0, 0);
    checks++; if ({rom_en, rom_x} !== {1'b1, 3'd0}) begin errors++; $display("FAIL pos_bypass_applied got en=%b x=%0d want 1,0", rom_en, rom_x); end
  endtask

  task automatic test_flash();
    step(0, 0, 0, 0, 0, 0, 1, 0);
    for (int f = 0; f < 8; f++) begin
      step(202, 103, 0, 0, 0, 0, (f == 2), 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (pix_on !== 1'((f % 2) == 1)) begin errors++;
        $display("FAIL flash_frame%0d got pix_on=%b want %b", f, pix_on, (f % 2) == 1); end
      checks++; if (obj_alive !== 1'b1) begin errors++; $display("FAIL flash_alive%0d got %b want 1", f, obj_alive); end
      step(0, 0, 1, 0, 0, 0, 0, 0);
    end
    checks++; if (obj_alive !== 1'b0) begin errors++; $display("FAIL flash_to_dead got %b want 0", obj_alive); end
    for (int i = 0; i < 40; i++) begin
      step(198 + (i % 8), 98 + (i / 8), 0, 0, 0, 0, (i == 5), 0);
      checks++; if ({rom_en, pix_on, obj_alive} !== 3'b000) begin errors++;
        $display("FAIL dead_quiet%0d got en=%b pix=%b alive=%b want 000", i, rom_en, pix_on, obj_alive); end
    end
  endtask

  task automatic test_async_reset();
    step(300, 200, 1, 1, 300, 200, 0, 0);
    step(301, 201, 0, 0, 0, 0, 0, 0);
    step(302, 202, 0, 0, 0, 0, 0, 0);
    checks++; if ({rom_en, pix_on, obj_alive} !== {2'b11, 1'b1}) begin errors++;
      $display("FAIL async_setup got en=%b pix=%b alive=%b want 111", rom_en, pix_on, obj_alive); end
    #2 rst_n = 0;
    #1;
    checks++; if ({rom_en, pix_on, obj_alive, pos_ready} !== 4'b0001) begin errors++;
      $display("FAIL async_reset got en=%b pix=%b alive=%b rdy=%b want 0001", rom_en, pix_on, obj_alive, pos_ready); end
    model_reset();
    @(negedge clk); rst_n = 1;
  endtask

`ifdef OBJ_SPRITE_MIRROR_EN
  task automatic test_mirror();
    step(0, 0, 1, 1, 100, 50, 0, 0);
    step(100, 50, 0, 0, 0, 0, 0, 1);
    checks++; if (rom_x !== 3'd5) begin errors++; $display("FAIL mirror_on got rom_x=%0d want 5", rom_x); end
    step(100, 50, 0, 0, 0, 0, 0, 0);
    checks++; if (rom_x !== 3'd0) begin errors++; $display("FAIL mirror_off got rom_x=%0d want 0", rom_x); end
  endtask
`endif

  task automatic test_random();
    bit pv, mir;
    int qx, qy, px, py;
    pv = 0; qx = 0; qy = 0;
    bitmap = {$urandom, $urandom};
    for (int i = 0; i < 3000; i++) begin
      if (!(pv && !e_ready)) begin
        pv = ($urandom_range(0, 3) == 0);
        qx = $urandom_range(0, 1023);
        qy = $urandom_range(0, 1023);
      end
      px = (m_cx - 3 + $urandom_range(0, 11)) & 1023;
      py = (m_cy - 3 + $urandom_range(0, 11)) & 1023;
`ifdef OBJ_SPRITE_MIRROR_EN
      mir = 1'($urandom_range(0, 1));
`else
      mir = 0;
`endif
      step(px, py, ($urandom_range(0, 29) == 0), pv, qx, qy, ($urandom_range(0, 59) == 0), mir);
      checks++; if ({rom_en, rom_x, rom_y} !== {1'(e_en), 3'(e_rx), 3'(e_ry)}) begin errors++;
        $display("FAIL rand_rom@%0d got en=%b x=%0d y=%0d want en=%b x=%0d y=%0d", i, rom_en, rom_x, rom_y, e_en, e_rx, e_ry); end
      checks++; if (pix_on !== e_pix) begin errors++; $display("FAIL rand_pix_on@%0d got %b want %b", i, pix_on, e_pix); end
      checks++; if (obj_alive !== e_alive) begin errors++; $display("FAIL rand_alive@%0d got %b want %b", i, obj_alive, e_alive); end
      checks++; if (pos_ready !== e_ready) begin errors++; $display("FAIL rand_ready@%0d got %b want %b", i, pos_ready, e_ready); end
    end
  endtask

  initial begin
    bitmap = {$urandom, $urandom};
    bitmap[3 * 8 + 2] = 1'b1;
    test_reset();
    test_spawn();
    test_scan();
    test_position();
    test_flash();
    test_async_reset();
`ifdef OBJ_SPRITE_MIRROR_EN
    test_mirror();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
